conv_img_src: RTL
=================

// Module: conv_img_src
// PURPOSE
//  Frame source for the convolution datapath: the transmit end of the data/valid/running pixel stream.
//  Holds one N x N frame in an internal RAM, loaded through a simple write port.
//  On start, streams the frame in raster order with valid/ready backpressure and frame/line markers.
//  Sits between the host/loader and the convolutor input.
// PARAMETERS
//  N           100  frame width = height, in pixels
//  DATA_WIDTH  16   pixel width, Q-format, passed through untouched
//  Q           5    fractional bits; informational only, no arithmetic here
//  AW          $clog2(N*N)  RAM address width (localparam)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    reset, asynchronous, active-low
//  wr_en_i    in   1    RAM write strobe; ignored while running_o=1
//  wr_addr_i  in   AW   write address, raster index row*N+col
//  wr_data_i  in   DW   write pixel
//  start_i    in   1    start one frame; sampled only in IDLE
//  ready_i    in   1    downstream accepts the beat when valid_o & ready_i
//  data_o     out  DW   pixel
//  valid_o    out  1    data_o valid
//  sof_o      out  1    qualifies first beat of frame
//  eol_o      out  1    qualifies last beat of each row
//  running_o  out  1    frame in progress
//  done_o     out  1    one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=IDLE, counters 0; RAM contents not cleared.
//  FSM: IDLE -start_i-> RUN -last read issued-> DRAIN -last beat accepted-> IDLE (done_o=1 that cycle).
//  start_i at edge t: running_o=1 from t+1; first valid_o no earlier than t+2 (sync RAM read, 1 cycle).
//  Reads issued in raster order, col then row; row/col counters wrap col N-1 -> 0, row++.
//  Throughput 1 beat/cycle while ready_i=1; skid buffer (2 entries) absorbs read-in-flight beat
//  when ready_i drops; no beat lost or duplicated; data_o/flags stable while valid_o & ~ready_i.
//  Reads stall when skid buffer holds 2 entries (or 1 entry plus 1 read in flight).
//  Exactly N*N beats (no PAD) per frame; sof_o on beat 0, eol_o on beats with col=N-1.
//  running_o falls with done_o's cycle+1 (same edge FSM re-enters IDLE); start_i in that cycle is accepted.
//  start_i while running_o=1: ignored. wr_en_i while running_o=1: ignored, RAM unchanged.
//  wr_en_i and start_i same cycle in IDLE: write takes effect, frame sees the new value.
//  rst asserted mid-frame: stream aborts immediately, no done_o, valid_o=0.
// CONFIGURATION
//  CONV_IMG_SRC_PAD_EN defined: frame streamed as (N+2) x (N+2) with a one-pixel zero border;
//   border beats emit data_o=0 with no RAM read; interior pixel (r,c) = RAM[(r-1)*N+(c-1)];
//   sof_o/eol_o/done_o refer to the padded frame; beat count (N+2)^2.
//  Undefined: no padding, N*N beats as above.
// STRUCTURE
//  Shared package conv_pkg: DATA_WIDTH/Q defaults, FSM state encodings (IDLE/RUN/DRAIN),
//   beat-flag bundle {sof, eol, data} width constant.
//  Sub-module stream_skid_buf (2-entry, parametrised width) carries {sof,eol,data}; FSM, counters
//   and RAM stay in this module.
// TESTING (bench uses N=4, DATA_WIDTH=16)
//  Load RAM[i]=i+1 for i=0..15, start, ready_i=1 -> 16 beats 1..16 consecutive, sof on 1,
//   eol on 4,8,12,16, done_o one cycle after beat 16 accepted, running_o then 0.
//  Same frame, ready_i toggled 1,0,0,1 repeating -> identical 16-beat sequence, no gaps lost/dup,
//   data_o held steady through every stalled cycle.
//  start_i pulsed at beat 5 and wr_en_i writing RAM[0]=16'hFFFF mid-frame -> no restart, next frame
//   still starts with 1.
//  Assert rst=0 at beat 7 -> valid_o/running_o drop asynchronously, no done_o; next start gives beat 1 first.
//  start_i held high continuously -> back-to-back frames, second sof_o on beat 17 value 1.
//  CONV_IMG_SRC_PAD_EN build, same RAM -> 36 beats; first 7 and last 7 = 0, beat 8 = 1, eol every 6th.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: pixel format defaults,
// frame-source FSM encoding and the width of the {sof, eol, data} beat bundle.
package conv_pkg;

   localparam int DATA_WIDTH_DEF = 16;
   localparam int Q_DEF          = 5;

   // sof and eol travel with every pixel
   localparam int FLAG_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } src_state_t;

   function automatic int beat_width(input int dw);
      return dw + FLAG_W;
   endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer. Entry 0 is always the head presented downstream, so
// the output word stays put while the consumer stalls. A push into a full
// buffer is only accepted when the head leaves in the same cycle.
module stream_skid_buf #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic         valid,
   output logic [W-1:0] data,
   output logic [1:0]   count
);

   logic [1:0]   cnt;
   logic [W-1:0] ent0_p0;
   logic [W-1:0] ent1_p0;
   logic         pop_ok;
   logic         push_ok;

   assign pop_ok  = pop && (cnt != 2'd0);
   assign push_ok = push && ((cnt != 2'd2) || pop_ok);

   // occupancy counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 2'd0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // entry storage: shift toward the head on pop, fill the first free slot on push
   always_ff @(posedge clk) begin
      case ({push_ok, pop_ok})
         2'b10: begin
            if (cnt == 2'd0) ent0_p0 <= push_data;
            else             ent1_p0 <= push_data;
         end
         2'b01: ent0_p0 <= ent1_p0;
         2'b11: begin
            if (cnt == 2'd1) begin
               ent0_p0 <= push_data;
            end else begin
               ent0_p0 <= ent1_p0;
               ent1_p0 <= push_data;
            end
         end
         default: ;
      endcase
   end

   assign valid = (cnt != 2'd0);
   assign data  = ent0_p0;
   assign count = cnt;

endmodule

// File: rtl/conv_img_src.sv
// Frame source for the convolution datapath. Holds one N x N frame in a RAM
// loaded through a write port and, on start, streams it in raster order with
// valid/ready backpressure, sof/eol markers and a done pulse.
// Optional build macro CONV_IMG_SRC_PAD_EN: stream an (N+2) x (N+2) frame
// with a one-pixel zero border around the stored image.
module conv_img_src
   import conv_pkg::*;
#(
   parameter int  N          = 100,
   parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int  Q          = Q_DEF,
   localparam int AW         = (N * N > 1) ? $clog2(N * N) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  start_i,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  sof_o,
   output logic                  eol_o,
   output logic                  running_o,
   output logic                  done_o
);

`ifdef CONV_IMG_SRC_PAD_EN
   localparam int NP  = N + 2;
   localparam bit PAD = 1'b1;
`else
   localparam int NP  = N;
   localparam bit PAD = 1'b0;
`endif

   localparam int CW = (NP > 1) ? $clog2(NP) : 1;
   localparam int BW = beat_width(DATA_WIDTH);
   localparam logic [CW-1:0] POS_LAST = CW'(NP - 1);
   // border pixel: 0.0 in the Q-format, the all-zero word whatever the binary point
   localparam logic [DATA_WIDTH-1:0] PIX_ZERO = DATA_WIDTH'(0) << Q;

   src_state_t state;
   src_state_t state_nxt;

   logic [DATA_WIDTH-1:0] mem [N*N];

   logic [CW-1:0]         row_p0;
   logic [CW-1:0]         col_p0;
   logic [AW-1:0]         addr_p0;
   logic                  border;
   logic                  last_pos;
   logic                  issue;

   logic                  vld_p1;
   logic                  sof_p1;
   logic                  eol_p1;
   logic                  border_p1;
   logic [DATA_WIDTH-1:0] rd_data_p1;
   logic [BW-1:0]         beat_p1;

   logic                  sk_valid;
   logic [BW-1:0]         sk_beat;
   logic [1:0]            sk_cnt;
   logic                  pop;
   logic [2:0]            occ_next;
   logic                  last_acc;
   logic                  done_p1;

   assign pop      = sk_valid && ready_i;
   // skid occupancy after this edge, counting the beat already leaving the RAM
   assign occ_next = {1'b0, sk_cnt} + {2'b00, vld_p1} - {2'b00, pop};
   assign issue    = (state == ST_RUN) && (occ_next <= 3'd1);
   assign border   = PAD && ((row_p0 == '0) || (row_p0 == POS_LAST) ||
                             (col_p0 == '0) || (col_p0 == POS_LAST));
   assign last_pos = (row_p0 == POS_LAST) && (col_p0 == POS_LAST);
   assign last_acc = (state == ST_DRAIN) && pop && (sk_cnt == 2'd1) && !vld_p1;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // FSM next state: run until the last read is issued, drain until it is accepted
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start_i)           state_nxt = ST_RUN;
         ST_RUN:   if (issue && last_pos) state_nxt = ST_DRAIN;
         ST_DRAIN: if (last_acc)          state_nxt = ST_IDLE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   // ---- stage p0: raster position and RAM address of the next beat ----
   // raster counters, col fastest; RAM address advances on interior beats only
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_p0  <= '0;
         col_p0  <= '0;
         addr_p0 <= '0;
      end else if (state == ST_IDLE) begin
         row_p0  <= '0;
         col_p0  <= '0;
         addr_p0 <= '0;
      end else if (issue) begin
         if (!border) addr_p0 <= addr_p0 + AW'(1);
         if (col_p0 == POS_LAST) begin
            col_p0 <= '0;
            row_p0 <= (row_p0 == POS_LAST) ? '0 : row_p0 + CW'(1);
         end else begin
            col_p0 <= col_p0 + CW'(1);
         end
      end
   end

   // frame RAM: host writes only while idle, synchronous read for the stream
   always_ff @(posedge clk) begin
      if (wr_en_i && (state == ST_IDLE)) mem[wr_addr_i] <= wr_data_i;
      if (issue && !border)              rd_data_p1 <= mem[addr_p0];
   end

   // ---- stage p1: RAM output and beat flags, valid travels as vld_p1 ----
   // beat flags captured alongside the read
   always_ff @(posedge clk) begin
      if (issue) begin
         sof_p1    <= (row_p0 == '0) && (col_p0 == '0);
         eol_p1    <= (col_p0 == POS_LAST);
         border_p1 <= border;
      end
   end

   // read-in-flight marker and done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         done_p1 <= 1'b0;
      end else begin
         vld_p1  <= issue;
         done_p1 <= last_acc;
      end
   end

   assign beat_p1 = {sof_p1, eol_p1, border_p1 ? PIX_ZERO : rd_data_p1};

   // ---- stage p2: skid buffer facing the consumer ----
   stream_skid_buf #(
      .W (BW)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (vld_p1),
      .push_data (beat_p1),
      .pop       (ready_i),
      .valid     (sk_valid),
      .data      (sk_beat),
      .count     (sk_cnt)
   );

   assign valid_o   = sk_valid;
   assign data_o    = sk_valid ? sk_beat[DATA_WIDTH-1:0] : '0;
   assign sof_o     = sk_valid && sk_beat[BW-1];
   assign eol_o     = sk_valid && sk_beat[BW-2];
   assign running_o = (state != ST_IDLE);
   assign done_o    = done_p1;

endmodule
